// File: rtl/drum_pkg.sv
// Shared constants, scheduler state encoding and grid-dimension clamp for the drum engine.
package drum_pkg;

  localparam int unsigned MAX_DIM      = 30;
  localparam int unsigned DIM_W        = 5;
  localparam int unsigned MAX_INFLIGHT = 4;
  localparam int unsigned OVR_W        = 8;
  localparam int unsigned RHO_W        = 5;
  localparam int unsigned INF_W        = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SWAP  = 2'd3
  } sched_state_e;

  // Keeps the grid edge inside the range the engine's address generator supports.
  function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] d);
    logic [DIM_W-1:0] r;
    if (d < DIM_W'(2))             r = DIM_W'(2);
    else if (d > DIM_W'(MAX_DIM))  r = DIM_W'(MAX_DIM);
    else                           r = d;
    return r;
  endfunction

endpackage

// File: rtl/node_index_counter.sv
// Row-major raster counter over a dim x dim grid; wraps to (0,0) after the last node.
module node_index_counter
  import drum_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic [DIM_W-1:0] dim_i,
  output logic [DIM_W-1:0] row_o,
  output logic [DIM_W-1:0] col_o,
  output logic             last_c_o
);

  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] dim_m1;
  logic             col_end;

  assign dim_m1   = dim_i - DIM_W'(1);
  assign col_end  = (col_q == dim_m1);
  assign last_c_o = col_end && (row_q == dim_m1);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (last_c_o) begin
        row_d = '0;
        col_d = '0;
      end else if (col_end) begin
        row_d = row_q + DIM_W'(1);
        col_d = '0;
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/drum_node_scheduler.sv
// Per-sample node-update sequencer: raster-issues grid nodes, tracks in-flight updates,
// flips the ping-pong bank at frame end and counts dropped sample ticks.
module drum_node_scheduler
  import drum_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic [DIM_W-1:0] grid_dim,
  input  logic [RHO_W-1:0] rho_sel,
  output logic             node_valid,
  input  logic             node_ready,
  output logic [DIM_W-1:0] node_row,
  output logic [DIM_W-1:0] node_col,
  output logic             node_edge,
  output logic             node_center,
  output logic [RHO_W-1:0] rho_latched,
  input  logic             done_pulse,
  output logic             bank_sel,
  output logic             busy,
  output logic             frame_done,
  output logic [OVR_W-1:0] overrun_cnt
);

  sched_state_e     state_q, state_d;
  logic [DIM_W-1:0] dim_q, dim_d;
  logic [RHO_W-1:0] rho_q, rho_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic             bank_q, bank_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;

  logic             start_c;
  logic             hs_c;
  logic             done_c;
  logic             last_c;
  logic [DIM_W-1:0] row_c, col_c;
  logic [DIM_W-1:0] dim_m1;
  logic             in_issue;

  node_index_counter u_idx (
    .clk       (CLOCK_50),
    .rst_n     (reset),
    .clear_i   (start_c),
    .advance_i (hs_c),
    .dim_i     (dim_q),
    .row_o     (row_c),
    .col_o     (col_c),
    .last_c_o  (last_c)
  );

  assign in_issue   = (state_q == ST_ISSUE);
  assign node_valid = in_issue && (inflight_q < INF_W'(MAX_INFLIGHT));
  assign hs_c       = node_valid && node_ready;
  // A completion with nothing outstanding is spurious and dropped.
  assign done_c     = done_pulse && (inflight_q != '0);
  assign start_c    = (state_q == ST_IDLE) && sample_tick;

  always_comb begin
    inflight_d = inflight_q;
    if (hs_c && !done_c)      inflight_d = inflight_q + INF_W'(1);
    else if (!hs_c && done_c) inflight_d = inflight_q - INF_W'(1);
  end

  always_comb begin
    state_d = state_q;
    dim_d   = dim_q;
    rho_d   = rho_q;
    bank_d  = bank_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          dim_d   = clamp_dim(grid_dim);
          rho_d   = rho_sel;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (hs_c && last_c) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((inflight_q == '0) || ((inflight_q == INF_W'(1)) && done_c)) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        bank_d  = ~bank_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ticks arriving while a frame (or its swap cycle) is in progress are lost.
  always_comb begin
    ovr_d = ovr_q;
    if (sample_tick && (state_q != ST_IDLE) && (ovr_q != '1)) ovr_d = ovr_q + OVR_W'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dim_q      <= '0;
      rho_q      <= '0;
      inflight_q <= '0;
      bank_q     <= 1'b0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      dim_q      <= dim_d;
      rho_q      <= rho_d;
      inflight_q <= inflight_d;
      bank_q     <= bank_d;
      ovr_q      <= ovr_d;
    end
  end

  assign dim_m1      = dim_q - DIM_W'(1);
  assign node_row    = row_c;
  assign node_col    = col_c;
  assign node_edge   = in_issue && ((row_c == '0) || (col_c == '0) ||
                                    (row_c == dim_m1) || (col_c == dim_m1));
  assign node_center = in_issue && (row_c == (dim_q >> 1)) && (col_c == (dim_q >> 1));
  assign rho_latched = rho_q;
  assign bank_sel    = bank_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = (state_q == ST_SWAP);
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_drum_node_scheduler.sv
// Directed bench for drum_node_scheduler with an engine model returning completions in order.
module tb_drum_node_scheduler;

  logic       CLOCK_50;
  logic       reset;
  logic       sample_tick;
  logic [4:0] grid_dim;
  logic [4:0] rho_sel;
  logic       node_valid;
  logic       node_ready;
  logic [4:0] node_row;
  logic [4:0] node_col;
  logic       node_edge;
  logic       node_center;
  logic [4:0] rho_latched;
  logic       done_pulse;
  logic       bank_sel;
  logic       busy;
  logic       frame_done;
  logic [7:0] overrun_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_bank = 0;
  int exp_ovr  = 0;

  drum_node_scheduler dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .sample_tick (sample_tick),
    .grid_dim    (grid_dim),
    .rho_sel     (rho_sel),
    .node_valid  (node_valid),
    .node_ready  (node_ready),
    .node_row    (node_row),
    .node_col    (node_col),
    .node_edge   (node_edge),
    .node_center (node_center),
    .rho_latched (rho_latched),
    .done_pulse  (done_pulse),
    .bank_sel    (bank_sel),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun_cnt (overrun_cnt)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sample frame; engine completes each request 3 cycles after acceptance, never before done_hold.
  task automatic run_frame(input string tag, input int gd, input int d, input int rho,
                           input int ready_mode, input int done_hold,
                           input int tick_from, input int tick_n,
                           input int gd_new_at, input int gd_new);
    int due[$];
    int k, er, ec, n_hs, infl, hr, hc;
    bit seen, held, dn, hs;
    due.delete();
    k = 0; er = 0; ec = 0; n_hs = 0; infl = 0; seen = 0; held = 0; hr = 0; hc = 0;
    grid_dim = 5'(gd);
    rho_sel = 5'(rho);
    sample_tick = 1'b1;
    @(posedge CLOCK_50); #1;
    sample_tick = 1'b0;
    rho_sel = ~5'(rho);
    while (!seen) begin
      node_ready  = (ready_mode == 0) ? 1'b1 : (k % 3 == 0);
      sample_tick = (k >= tick_from) && (k < tick_from + tick_n);
      if (k == gd_new_at) grid_dim = 5'(gd_new);
      dn = (due.size() > 0) && (due[0] <= k) && (k >= done_hold);
      if (dn) void'(due.pop_front());
      done_pulse = dn;
      #2;
      if (k == 0) check({tag, " busy_start"}, 32'(busy), 1);
      if (n_hs < d * d) check({tag, " valid"}, 32'(node_valid), (infl < 4) ? 1 : 0);
      else              check({tag, " valid_drain"}, 32'(node_valid), 0);
      if (held && node_valid) begin
        check({tag, " held_row"}, 32'(node_row), hr);
        check({tag, " held_col"}, 32'(node_col), hc);
      end
      held = node_valid && !node_ready;
      hr = 32'(node_row); hc = 32'(node_col);
      hs = node_valid && node_ready;
      if (hs) begin
        check({tag, " row"}, 32'(node_row), er);
        check({tag, " col"}, 32'(node_col), ec);
        check({tag, " edge"}, 32'(node_edge),
              (er == 0 || ec == 0 || er == d - 1 || ec == d - 1) ? 1 : 0);
        check({tag, " center"}, 32'(node_center), (er == d / 2 && ec == d / 2) ? 1 : 0);
        due.push_back(k + 3);
        n_hs++;
        if (ec == d - 1) begin ec = 0; er++; end else ec++;
      end
      if (frame_done) begin
        seen = 1;
        check({tag, " all_issued_at_swap"}, n_hs, d * d);
      end
      if (sample_tick && exp_ovr < 255) exp_ovr++;
      infl = infl + (hs ? 1 : 0) - (dn ? 1 : 0);
      @(posedge CLOCK_50); #1;
      k++;
      if (k > 4000) begin
        check({tag, " timeout"}, 0, 1);
        seen = 1;
      end
    end
    sample_tick = 1'b0;
    done_pulse  = 1'b0;
    node_ready  = 1'b0;
    exp_bank ^= 1;
    #2;
    check({tag, " n_issued"}, n_hs, d * d);
    check({tag, " inflight_end"}, infl, 0);
    check({tag, " busy_end"}, 32'(busy), 0);
    check({tag, " frame_done_pulse"}, 32'(frame_done), 0);
    check({tag, " bank"}, 32'(bank_sel), exp_bank);
    check({tag, " rho"}, 32'(rho_latched), rho);
    check({tag, " overrun"}, 32'(overrun_cnt), exp_ovr);
    @(posedge CLOCK_50); #1;
  endtask

  initial begin
    int due[$];
    int k;
    bit dn;
    reset = 1'b0; sample_tick = 1'b0; grid_dim = 5'd4; rho_sel = 5'd0;
    node_ready = 1'b0; done_pulse = 1'b0;
    #12;
    check("rst valid", 32'(node_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst bank", 32'(bank_sel), 0);
    check("rst frame_done", 32'(frame_done), 0);
    check("rst overrun", 32'(overrun_cnt), 0);
    check("rst edge", 32'(node_edge), 0);
    check("rst center", 32'(node_center), 0);
    check("rst row", 32'(node_row), 0);
    check("rst col", 32'(node_col), 0);
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    check("idle busy", 32'(busy), 0);

    run_frame("basic4", 4, 4, 5'h0a, 0, 0, -1, 0, -1, 0);

    // Abort mid-frame once node (1,2) is being requested.
    grid_dim = 5'd4; sample_tick = 1'b1;
    @(posedge CLOCK_50); #1;
    sample_tick = 1'b0;
    due.delete();
    k = 0;
    node_ready = 1'b1;
    while (k < 60) begin
      dn = (due.size() > 0) && (due[0] <= k);
      if (dn) void'(due.pop_front());
      done_pulse = dn;
      #2;
      if (node_valid && node_row == 5'd1 && node_col == 5'd2) break;
      if (node_valid) due.push_back(k + 3);
      @(posedge CLOCK_50); #1;
      k++;
    end
    check("abort reached", (k < 60) ? 1 : 0, 1);
    check("abort bank_before", 32'(bank_sel), 1);
    reset = 1'b0; done_pulse = 1'b0; node_ready = 1'b0;
    #1;
    check("abort valid", 32'(node_valid), 0);
    check("abort busy", 32'(busy), 0);
    check("abort bank", 32'(bank_sel), 0);
    check("abort row", 32'(node_row), 0);
    check("abort col", 32'(node_col), 0);
    exp_bank = 0;
    exp_ovr  = 0;
    #3;
    reset = 1'b1;
    @(posedge CLOCK_50); #1;

    run_frame("after_rst", 4, 4, 5'h03, 0, 0, -1, 0, -1, 0);
    run_frame("stall", 4, 4, 5'h11, 0, 10, -1, 0, -1, 0);
    run_frame("backpressure", 4, 4, 5'h1f, 1, 0, -1, 0, -1, 0);
    run_frame("overrun1", 4, 4, 5'h07, 0, 0, 5, 1, -1, 0);
    check("overrun one", 32'(overrun_cnt), 1);
    run_frame("clamp_lo", 1, 2, 5'h02, 0, 0, -1, 0, -1, 0);
    run_frame("clamp_hi", 31, 30, 5'h15, 0, 0, 1, 300, -1, 0);
    check("overrun sat", 32'(overrun_cnt), 255);
    run_frame("latch12", 12, 12, 5'h0c, 0, 0, -1, 0, 20, 4);
    run_frame("next4", 4, 4, 5'h04, 0, 0, -1, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/drum_node_scheduler.md
Name: drum_node_scheduler

Overview:
- Per-audio-sample sequencer for the drum's 2D wave-equation node-update engine.
- On each sample tick, walks every node of the active N x N grid in row-major order and issues one update request per node over a valid/ready handshake.
- Tracks in-flight updates and flips the ping-pong state-memory bank when the frame completes.
- Flags sample-rate overruns; sits between the audio-codec sample strobe and the update datapath inside drum.

Parameters:
- MAX_DIM, 30, largest supported grid edge (nodes per row/column).
- DIM_W, 5, width of grid_dim and of the row/column indices.
- MAX_INFLIGHT, 4, maximum issued-but-not-completed updates (engine pipeline depth).
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle pulse per audio sample (DACLRCK edge, already synchronised).
- grid_dim  in  DIM_W  requested grid edge (SW[4:0]); latched at frame start.
- rho_sel  in  5  tension/damping select (SW[9:5]); latched at frame start.
- node_valid  out  1  update request valid.
- node_ready  in  1  engine accepts request.
- node_row  out  DIM_W  row index of request.
- node_col  out  DIM_W  column index of request.
- node_edge  out  1  node lies on the boundary (row or col is 0 or dim-1).
- node_center  out  1  node is (dim>>1, dim>>1), the audio tap.
- rho_latched  out  5  rho_sel captured for the current frame.
- done_pulse  in  1  engine completed one update (in order, one per cycle max).
- bank_sel  out  1  ping-pong bank read as u(n); the other bank is u(n-1)/write.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when the frame is retired.
- overrun_cnt  out  OVR_W  saturating count of dropped ticks.

Behaviour:
- Reset (async, reset=0): state IDLE, all outputs 0, row/col/inflight/overrun_cnt 0, bank_sel 0.
- Grid clamp at latch: dim = grid_dim<2 ? 2 : grid_dim>MAX_DIM ? MAX_DIM : grid_dim.
- FSM states: IDLE, ISSUE, DRAIN, SWAP.
- IDLE: when sample_tick=1, latch dim and rho, zero row/col, go to ISSUE next cycle. busy=1 from that next cycle.
- ISSUE:
  - node_valid=1 whenever inflight<MAX_INFLIGHT; otherwise node_valid=0 (stall).
  - The request and its indices stay stable until accepted.
  - A handshake (valid and ready) advances col; when col=dim-1, col wraps to 0 and row increments.
  - The handshake on node (dim-1, dim-1) moves the FSM to DRAIN.
- Inflight counter: +1 on handshake, -1 on done_pulse. When both occur in the same cycle, the count is unchanged. Never exceeds MAX_INFLIGHT. A done_pulse with inflight=0 is ignored.
- DRAIN: node_valid=0. When inflight=0, or becomes 0 this cycle through done_pulse, go to SWAP.
- SWAP (one cycle): toggle bank_sel, frame_done=1, go to IDLE; busy=0 from IDLE onward.
- Minimum frame length: dim*dim + 2 cycles plus drain time. At dim=12 with ready held high, a frame fits well inside one 48 kHz sample period.
- Overrun: sample_tick while state is not IDLE (including the SWAP cycle) is dropped and increments overrun_cnt, which saturates at all-ones. The tick is not queued.
- node_edge and node_center are combinational from row, col and the latched dim.
- Mid-frame changes to grid_dim or rho_sel have no effect until the next frame.
- Reset mid-frame aborts immediately. Inflight is discarded, and bank_sel returns to 0.

Decomposition:
- drum_pkg:
  - FSM state enum (IDLE, ISSUE, DRAIN, SWAP).
  - MAX_DIM/DIM_W defaults.
  - The dim clamp as a function, shared with the update engine's address generator.
- Sub-module node_index_counter: row/col raster counter with advance, last-node flag and clear.
- The FSM and inflight tracking stay in the top.

Test Plan:
- grid_dim=4, ready=1, done_pulse 3 cycles after each handshake, one tick:
  - 16 handshakes in order (0,0)..(3,3).
  - node_edge=0 only for (1,1),(1,2),(2,1),(2,2); node_center only at (2,2).
  - one frame_done; bank_sel 0->1.
- grid_dim=4, no done_pulse for the first 10 cycles:
  - node_valid drops after 4 handshakes; inflight=4.
  - issue resumes one cycle after the first done_pulse.
- Backpressure: ready toggled 1,0,0,1... -> indices held stable while ready=0; no skipped or duplicated node; still 16 issues.
- Overrun: second tick 5 cycles after the first (dim=4) -> overrun_cnt=1, frame unaffected. 300 overrun ticks -> overrun_cnt saturates at 255.
- Clamp and latch:
  - grid_dim=1 -> 4 nodes.
  - grid_dim=31 -> 900 nodes.
  - grid_dim changed 12->4 mid-frame -> frame still issues 144 nodes; the next frame issues 16.
- Reset asserted mid-ISSUE at node (1,2) -> node_valid, busy, and bank_sel 0 immediately. Next tick starts at (0,0).
